// File: rtl/l1_i_refill_unit.sv
// L1 I-cache refill unit: issues one L2 line request per miss,
// assembles the returned beats into a line and hands it back to L1.
module l1_i_refill_unit #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8,
  parameter int LINE_W = 512,
  parameter int BUS_W  = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read_L1_L2,
  input  logic [TNUM_2-1:0]        tag_L1_L2,
  input  logic [INUM_2-1:0]        index_L1_L2,
  input  logic                     way,
  input  logic                     flush,
  output logic                     ready_L2_L1,
  output logic [LINE_W-1:0]        refill_data,
  output logic [INUM_2-1:0]        refill_index,
  output logic                     refill_way,
  output logic                     req_L1_L2,
  output logic [TNUM_2+INUM_2-1:0] addr_L1_L2,
  input  logic                     ack_L2_L1,
  input  logic                     dvalid_L2_L1,
  input  logic [BUS_W-1:0]         data_L2_L1,
  input  logic                     last_L2_L1,
  output logic                     err
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    DONE,
    DRAIN
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                abort_q;
  logic [INUM_2-1:0]   idx_q;
  logic                way_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_nx;
  logic                at_last;
  logic                perr;

  assign at_last = (cnt == LAST);

  // line buffer with the current beat merged into its slot
  always_comb begin
    line_nx = line_q;
    line_nx[cnt*BUS_W +: BUS_W] = data_L2_L1;
  end

  // framing check: beats must land in FILL/DRAIN, last only on final slot
  always_comb begin
    perr = 1'b0;
    if (dvalid_L2_L1) begin
      if (state == FILL || state == DRAIN)
        perr = (last_L2_L1 != at_last);
      else
        perr = 1'b1;
    end
  end

  // refill FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      abort_q      <= 1'b0;
      idx_q        <= '0;
      way_q        <= 1'b0;
      line_q       <= '0;
      ready_L2_L1  <= 1'b0;
      refill_data  <= '0;
      refill_index <= '0;
      refill_way   <= 1'b0;
      req_L1_L2    <= 1'b0;
      addr_L1_L2   <= '0;
      err          <= 1'b0;
    end else begin
      ready_L2_L1 <= 1'b0;
      if (perr)
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (read_L1_L2 && !flush) begin
            addr_L1_L2 <= {tag_L1_L2, index_L1_L2};
            idx_q      <= index_L1_L2;
            way_q      <= way;
            req_L1_L2  <= 1'b1;
            abort_q    <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (flush)
            abort_q <= 1'b1;
          if (ack_L2_L1) begin
            req_L1_L2 <= 1'b0;
            cnt       <= '0;
            abort_q   <= 1'b0;
            state     <= (abort_q || flush) ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (dvalid_L2_L1)
            cnt <= cnt + 1'b1;
          if (flush) begin
            state <= (dvalid_L2_L1 && at_last) ? IDLE : DRAIN;
          end else if (dvalid_L2_L1) begin
            line_q <= line_nx;
            if (at_last) begin
              refill_data  <= line_nx;
              refill_index <= idx_q;
              refill_way   <= way_q;
              ready_L2_L1  <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (dvalid_L2_L1) begin
            cnt <= cnt + 1'b1;
            if (at_last)
              state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_i_refill_unit.sv
// Bench for l1_i_refill_unit: table vectors, hand sequences and
// randomized refills checked against a transaction-level model.
module tb_l1_i_refill_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         read = 1'b0;
  logic [17:0]  tag = '0;
  logic [7:0]   index = '0;
  logic         way_i = 1'b0;
  logic         flush = 1'b0;
  logic         ready;
  logic [511:0] rdata;
  logic [7:0]   rindex;
  logic         rway;
  logic         req;
  logic [25:0]  addr;
  logic         ack = 1'b0;
  logic         dvalid = 1'b0;
  logic [127:0] data = '0;
  logic         last = 1'b0;
  logic         err;

  l1_i_refill_unit dut (
    .clk(clk), .rst(rst),
    .read_L1_L2(read), .tag_L1_L2(tag), .index_L1_L2(index),
    .way(way_i), .flush(flush),
    .ready_L2_L1(ready), .refill_data(rdata),
    .refill_index(rindex), .refill_way(rway),
    .req_L1_L2(req), .addr_L1_L2(addr),
    .ack_L2_L1(ack), .dvalid_L2_L1(dvalid),
    .data_L2_L1(data), .last_L2_L1(last), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int npulse = 0;
  int pcyc = 0;

  logic [127:0] beat_q [4];
  logic [511:0] m_line = '0;
  logic [7:0]   m_index = '0;
  logic         m_way = 1'b0;
  logic         m_err = 1'b0;

  typedef struct {
    logic [17:0] tg;
    logic [7:0]  ix;
    logic        w;
    int          ackd;
    logic [15:0] gp;
    int          fm;
    int          fb;
    int          bad;
    logic [7:0]  pat;
    logic        xr;
    int          xcyc;
  } vec_t;

  vec_t tbl [7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready) begin
      npulse++;
      pcyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [511:0] a,
                     input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // fm: 0 none, 1 flush in first REQ cycle, 2 flush cycle after beat fb
  task automatic txn(input logic [17:0] tg, input logic [7:0] ix,
                     input logic w, input int ackd,
                     input logic [15:0] gp, input int fm,
                     input int fb, input int bad,
                     input logic xr, input int xcyc);
    int t0;
    int np0;
    logic [25:0] xa;
    xa = {tg, ix};
    np0 = npulse;
    read = 1'b1; tag = tg; index = ix; way_i = w;
    @(posedge clk); #1;
    t0 = cyc;
    read = 1'b0;
    if (fm == 1) flush = 1'b1;
    for (int i = 0; i < ackd; i++) begin
      @(negedge clk);
      chk("req_wait", {req, addr}, {1'b1, xa});
      @(posedge clk); #1;
      flush = 1'b0;
    end
    ack = 1'b1;
    @(negedge clk);
    chk("req_ack", {req, addr}, {1'b1, xa});
    @(posedge clk); #1;
    ack = 1'b0; flush = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat (int'(gp[b*4 +: 4])) begin
        @(posedge clk); #1;
      end
      dvalid = 1'b1;
      data = beat_q[b];
      last = (b == 3) || (b == bad);
      @(posedge clk); #1;
      dvalid = 1'b0; last = 1'b0;
      if (fm == 2 && b == fb) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
    end
    if (xr) begin
      m_line  = {beat_q[3], beat_q[2], beat_q[1], beat_q[0]};
      m_index = ix;
      m_way   = w;
    end
    if (bad >= 0 && bad < 3) m_err = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pulses", 512'(npulse - np0), 512'(xr ? 1 : 0));
    if (xr)
      chk("pulse_cycle", 512'(pcyc - t0 + 1), 512'(xcyc));
    chk("req_idle", 512'(req), 512'(0));
    chk("line", rdata, m_line);
    chk("idx_way", {rindex, rway}, {m_index, m_way});
    chk("err", 512'(err), 512'(m_err));
  endtask

  task automatic fill_pat(input logic [7:0] pat);
    for (int b = 0; b < 4; b++)
      beat_q[b] = {16{pat + 8'(17 * b)}};
  endtask

  initial begin
    tbl[0] = '{18'h2A5F3, 8'h1C, 1'b1, 0, 16'h0000, 0, 0, 7, 8'h11, 1'b1, 6};
    tbl[1] = '{18'h12345, 8'h40, 1'b0, 3, 16'h0200, 0, 0, 7, 8'h05, 1'b1, 11};
    tbl[2] = '{18'h3FFFF, 8'h01, 1'b1, 0, 16'h0000, 2, 1, 7, 8'h60, 1'b0, 0};
    tbl[3] = '{18'h00ABC, 8'h02, 1'b0, 0, 16'h0000, 0, 0, 7, 8'h70, 1'b1, 6};
    tbl[4] = '{18'h0F0F0, 8'h80, 1'b1, 5, 16'h0000, 1, 0, 7, 8'h90, 1'b0, 0};
    tbl[5] = '{18'h15555, 8'hAA, 1'b1, 1, 16'h1111, 0, 0, 7, 8'hA1, 1'b1, 11};
    tbl[6] = '{18'h2AAAA, 8'h55, 1'b0, 0, 16'h0000, 0, 0, 1, 8'hC3, 1'b1, 6};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", {ready, req, addr, err, rway, rindex},
        '0);
    chk("reset_data", rdata, '0);

    for (int i = 0; i < 7; i++) begin
      fill_pat(tbl[i].pat);
      txn(tbl[i].tg, tbl[i].ix, tbl[i].w, tbl[i].ackd, tbl[i].gp,
          tbl[i].fm, tbl[i].fb, tbl[i].bad, tbl[i].xr, tbl[i].xcyc);
    end

    begin : reset_mid_fill
      int np0;
      np0 = npulse;
      fill_pat(8'hE0);
      @(posedge clk); #1;
      read = 1'b1; tag = 18'h01234; index = 8'h33; way_i = 1'b1;
      @(posedge clk); #1;
      read = 1'b0; ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      for (int b = 0; b < 2; b++) begin
        dvalid = 1'b1; data = beat_q[b];
        @(posedge clk); #1;
      end
      dvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ctl", {ready, req, addr, err, rway, rindex}, '0);
      chk("rst_mid_data", rdata, '0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_nopulse", 512'(npulse - np0), 512'(0));
      m_line = '0; m_index = '0; m_way = 1'b0; m_err = 1'b0;
      @(posedge clk); #1;
      fill_pat(8'h3C);
      txn(18'h2BEEF, 8'hFF, 1'b1, 0, 16'h0000, 0, 0, 7, 1'b1, 6);
    end

    for (int n = 0; n < 25; n++) begin
      int ackd, fm, fb, bad, xc;
      logic [15:0] gp;
      logic [17:0] tg;
      logic [7:0] ix;
      logic w;
      ackd = int'($urandom_range(0, 4));
      gp = '0;
      xc = 6 + ackd;
      for (int b = 0; b < 4; b++) begin
        gp[b*4 +: 4] = 4'($urandom_range(0, 2));
        xc += int'(gp[b*4 +: 4]);
      end
      fm = int'($urandom_range(0, 5));
      if (fm > 2) fm = 0;
      fb = int'($urandom_range(0, 2));
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : 7;
      tg = 18'($urandom);
      ix = 8'($urandom);
      w = 1'($urandom);
      for (int b = 0; b < 4; b++)
        beat_q[b] = {$urandom, $urandom, $urandom, $urandom};
      txn(tg, ix, w, ackd, gp, fm, fb, bad, fm == 0, xc);
    end

    begin : stray_beat
      int np0;
      np0 = npulse;
      @(posedge clk); #1;
      dvalid = 1'b1; data = '1; last = 1'b1;
      @(posedge clk); #1;
      dvalid = 1'b0; last = 1'b0;
      @(negedge clk);
      chk("stray_err", 512'(err), 512'(1));
      chk("stray_quiet", {ready, req, 30'(npulse - np0)}, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
